// File: rtl/seg_scan_if.sv
// Display-readback bus: the multiplexed 7-seg lines being monitored plus the decoded frame results.
// The display driver side is the master; the decoder consumes the lines and produces the frame.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          Segmentos;
    logic [DIGITS-1:0]   Anodos;
    logic [4*DIGITS-1:0] Dato;
    logic                Valido;
    logic                Error;
    logic [DIGITS-1:0]   Invalidos;

    modport master (
        output Segmentos,
        output Anodos,
        input  Dato,
        input  Valido,
        input  Error,
        input  Invalidos
    );

    modport slave (
        input  Segmentos,
        input  Anodos,
        output Dato,
        output Valido,
        output Error,
        output Invalidos
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Monitors an active-low multiplexed 7-seg bus, debounces each digit dwell, decodes the segment
// pattern back to a hex nibble and publishes a full frame once every digit has been captured.
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    seg_scan_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic {
        ST_WAIT,
        ST_HELD
    } dwell_state_t;

    logic [6:0]          seg_s1_reg;
    logic [6:0]          seg_s2_reg;
    logic [6:0]          seg_prev_reg;
    logic [DIGITS-1:0]   an_s1_reg;
    logic [DIGITS-1:0]   an_s2_reg;
    logic [DIGITS-1:0]   an_prev_reg;

    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    dwell_state_t        state_reg;
    dwell_state_t        state_next;

    logic                changed;
    logic [DIGITS-1:0]   an_low;
    logic                one_low;
    logic                capture;
    logic [DIGITS-1:0]   cap_vec;
    logic [4:0]          decoded;

    logic [3:0]          slot_reg [DIGITS];
    logic [DIGITS-1:0]   slot_inv_reg;
    logic [DIGITS-1:0]   mask_reg;
    logic [DIGITS-1:0]   mask_next;
    logic                publish;
    logic [4*DIGITS-1:0] frame;

    logic [4*DIGITS-1:0] dato_reg;
    logic                valido_reg;
    logic                error_reg;
    logic [DIGITS-1:0]   invalidos_reg;

    // Returns {invalid, nibble}; unknown patterns decode to nibble 0 with the invalid bit set.
    function automatic logic [4:0] decode_seg(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            7'b1000000: result = 5'h00;
            7'b1111001: result = 5'h01;
            7'b0100100: result = 5'h02;
            7'b0110000: result = 5'h03;
            7'b0011001: result = 5'h04;
            7'b0010010: result = 5'h05;
            7'b0000010: result = 5'h06;
            7'b1111000: result = 5'h07;
            7'b0000000: result = 5'h08;
            7'b0011000: result = 5'h09;
            7'b0001000: result = 5'h0A;
            7'b0000011: result = 5'h0B;
            7'b1000110: result = 5'h0C;
            7'b0100001: result = 5'h0D;
            7'b0000110: result = 5'h0E;
            7'b0001110: result = 5'h0F;
            default:    result = 5'h10;
        endcase
        return result;
    endfunction

    // Two-stage synchronizer plus a one-cycle history of the synced bus for change detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            seg_s1_reg   <= '1;
            seg_s2_reg   <= '1;
            seg_prev_reg <= '1;
            an_s1_reg    <= '1;
            an_s2_reg    <= '1;
            an_prev_reg  <= '1;
        end else begin
            seg_s1_reg   <= bus.Segmentos;
            seg_s2_reg   <= seg_s1_reg;
            seg_prev_reg <= seg_s2_reg;
            an_s1_reg    <= bus.Anodos;
            an_s2_reg    <= an_s1_reg;
            an_prev_reg  <= an_s2_reg;
        end
    end

    always_comb begin
        changed = (an_s2_reg != an_prev_reg) || (seg_s2_reg != seg_prev_reg);
        an_low  = ~an_s2_reg;
        one_low = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        decoded = decode_seg(seg_s2_reg);
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (changed) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT;
        end else begin
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    // Capture fires on the edge where the counter reaches its saturation value, once per dwell.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        if (changed) begin
            state_next = ST_WAIT;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (cnt_reg == CNT_PRE && one_low) begin
                        capture    = 1'b1;
                        state_next = ST_HELD;
                    end
                end
                ST_HELD: state_next = ST_HELD;
                default: state_next = ST_WAIT;
            endcase
        end
    end

    always_comb begin
        cap_vec   = capture ? an_low : '0;
        publish   = &mask_reg;
        mask_next = (publish ? '0 : mask_reg) | cap_vec;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mask_reg     <= '0;
            slot_inv_reg <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                slot_reg[i] <= 4'h0;
            end
        end else begin
            mask_reg <= mask_next;
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_vec[i]) begin
                    slot_reg[i]     <= decoded[3:0];
                    slot_inv_reg[i] <= decoded[4];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_frame
            assign frame[4*gi +: 4] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dato_reg      <= '0;
            valido_reg    <= 1'b0;
            error_reg     <= 1'b0;
            invalidos_reg <= '0;
        end else begin
            valido_reg <= publish;
            if (publish) begin
                dato_reg      <= frame;
                invalidos_reg <= slot_inv_reg;
                error_reg     <= |slot_inv_reg;
            end
        end
    end

    assign bus.Dato      = dato_reg;
    assign bus.Valido    = valido_reg;
    assign bus.Error     = error_reg;
    assign bus.Invalidos = invalidos_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized dwells checked
// against a run-length model of the raw display bus.
module tb_seg_scan_decoder;
    localparam int DIGITS = 4;
    localparam int STABLE = 8;

    logic Clk = 1'b0;
    logic Reset;

    seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_decoder #(
        .DIGITS(DIGITS),
        .STABLE_CYCLES(STABLE),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         due;
        int         idx;
        logic [3:0] nib;
        logic       inv;
    } cap_t;

    int checks = 0;
    int failures = 0;
    int edge_no = 0;

    logic [6:0] pat_tab [16];

    cap_t        pend [$];
    logic [10:0] m_last;
    int          m_run;
    logic [3:0]  m_slot [DIGITS];
    logic [3:0]  m_flag;
    logic [3:0]  m_mask;
    logic [15:0] m_dato;
    logic        m_err;
    logic [3:0]  m_inv;
    logic        m_valid;

    int          dut_pulses, mdl_pulses, out_mm;
    logic [15:0] dut_last_dato, mdl_last_dato;
    logic        dut_last_err, mdl_last_err;
    logic [3:0]  dut_last_inv, mdl_last_inv;

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] nib,
                                         output logic inv);
        nib = 4'h0;
        inv = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (pat_tab[n] == p) begin
                nib = n[3:0];
                inv = 1'b0;
            end
        end
    endfunction

    task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic rst);
        cap_t c;
        if (rst) begin
            pend.delete();
            m_last  = 11'h7FF;
            m_run   = 1;
            m_mask  = '0;
            m_flag  = '0;
            m_dato  = '0;
            m_err   = 1'b0;
            m_inv   = '0;
            m_valid = 1'b0;
            for (int i = 0; i < DIGITS; i++) m_slot[i] = 4'h0;
            return;
        end
        m_valid = 1'b0;
        if (m_mask == 4'hF) begin
            for (int i = 0; i < DIGITS; i++) m_dato[4*i +: 4] = m_slot[i];
            m_inv   = m_flag;
            m_err   = |m_flag;
            m_valid = 1'b1;
            m_mask  = '0;
        end
        while (pend.size() > 0 && pend[0].due == edge_no) begin
            c = pend.pop_front();
            m_slot[c.idx] = c.nib;
            m_flag[c.idx] = c.inv;
            m_mask[c.idx] = 1'b1;
        end
        if ({an, seg} == m_last) begin
            m_run++;
        end else begin
            m_last = {an, seg};
            m_run  = 1;
        end
        // A dwell that has lasted STABLE samples on a single selected digit lands 2 edges later.
        if (m_run == STABLE && $countones(~an) == 1) begin
            for (int i = 0; i < DIGITS; i++) if (!an[i]) c.idx = i;
            model_decode(seg, c.nib, c.inv);
            c.due = edge_no + 2;
            pend.push_back(c);
        end
    endtask

    task automatic cycle(input logic [3:0] an, input logic [6:0] seg, input logic rst);
        bus.Anodos    = an;
        bus.Segmentos = seg;
        Reset         = rst;
        @(posedge Clk);
        edge_no++;
        model_edge(an, seg, rst);
        #1;
        if (bus.Valido === 1'b1) begin
            dut_pulses++;
            dut_last_dato = bus.Dato;
            dut_last_err  = bus.Error;
            dut_last_inv  = bus.Invalidos;
            $display("publish t=%0t dato=%h err=%b inv=%b", $time, bus.Dato, bus.Error,
                     bus.Invalidos);
        end
        if (m_valid) begin
            mdl_pulses++;
            mdl_last_dato = m_dato;
            mdl_last_err  = m_err;
            mdl_last_inv  = m_inv;
        end
        if (bus.Valido !== m_valid || bus.Dato !== m_dato || bus.Error !== m_err ||
            bus.Invalidos !== m_inv) out_mm++;
    endtask

    task automatic clear_obs();
        dut_pulses = 0;
        mdl_pulses = 0;
        out_mm = 0;
        dut_last_dato = '0;
        mdl_last_dato = '0;
        dut_last_err = 1'b0;
        mdl_last_err = 1'b0;
        dut_last_inv = '0;
        mdl_last_inv = '0;
    endtask

    task automatic dwell(input int digit, input logic [6:0] seg, input int len);
        logic [3:0] an;
        an = 4'hF;
        an[digit] = 1'b0;
        for (int k = 0; k < len; k++) cycle(an, seg, 1'b0);
    endtask

    task automatic idle(input int len);
        for (int k = 0; k < len; k++) cycle(4'hF, 7'h7F, 1'b0);
    endtask

    task automatic test_reset();
        clear_obs();
        for (int k = 0; k < 3; k++) cycle(4'hF, 7'h7F, 1'b1);
        checks++;
        if (bus.Dato !== 16'h0 || bus.Valido !== 1'b0 || bus.Error !== 1'b0 ||
            bus.Invalidos !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs got dato=%h val=%b err=%b inv=%b want all zero",
                     bus.Dato, bus.Valido, bus.Error, bus.Invalidos);
        end
        idle(20);
        checks++;
        if (dut_pulses !== 0) begin
            failures++;
            $display("FAIL reset_no_pulse got=%0d want=0", dut_pulses);
        end
        checks++;
        if (out_mm !== 0) begin
            failures++;
            $display("FAIL reset_trace mismatched_cycles=%0d want=0", out_mm);
        end
    endtask

    task automatic test_scan();
        clear_obs();
        for (int pass = 0; pass < 2; pass++) begin
            dwell(0, 7'b1111001, 16);
            dwell(1, 7'b0100100, 16);
            dwell(2, 7'b0110000, 16);
            dwell(3, 7'b0011001, 16);
        end
        idle(4);
        checks++;
        if (dut_pulses !== 2) begin
            failures++;
            $display("FAIL scan_pulses got=%0d want=2", dut_pulses);
        end
        checks++;
        if (dut_last_dato !== 16'h4321 || dut_last_err !== 1'b0) begin
            failures++;
            $display("FAIL scan_dato got=%h err=%b want=4321 err=0", dut_last_dato, dut_last_err);
        end
        checks++;
        if (out_mm !== 0) begin
            failures++;
            $display("FAIL scan_trace mismatched_cycles=%0d want=0", out_mm);
        end
    endtask

    task automatic test_debounce();
        clear_obs();
        dwell(0, 7'b1111001, 16);
        dwell(1, 7'b0100100, 5);
        idle(10);
        dwell(2, 7'b0110000, 16);
        dwell(3, 7'b0011001, 16);
        idle(4);
        checks++;
        if (dut_pulses !== 0) begin
            failures++;
            $display("FAIL debounce_short_dwell got=%0d want=0", dut_pulses);
        end
        dwell(1, 7'b0100100, 2 + STABLE);
        idle(4);
        checks++;
        if (dut_pulses !== 1 || dut_last_dato !== 16'h4321) begin
            failures++;
            $display("FAIL debounce_publish got pulses=%0d dato=%h want 1 4321",
                     dut_pulses, dut_last_dato);
        end
        checks++;
        if (out_mm !== 0) begin
            failures++;
            $display("FAIL debounce_trace mismatched_cycles=%0d want=0", out_mm);
        end
    endtask

    task automatic test_invalid();
        clear_obs();
        dwell(0, 7'b1111001, 16);
        dwell(1, 7'b0100100, 16);
        dwell(2, 7'b1111111, 16);
        dwell(3, 7'b0011001, 16);
        idle(4);
        checks++;
        if (dut_pulses !== 1 || dut_last_dato !== 16'h4021) begin
            failures++;
            $display("FAIL invalid_dato got pulses=%0d dato=%h want 1 4021",
                     dut_pulses, dut_last_dato);
        end
        checks++;
        if (dut_last_inv !== 4'b0100 || dut_last_err !== 1'b1) begin
            failures++;
            $display("FAIL invalid_flags got inv=%b err=%b want 0100 1",
                     dut_last_inv, dut_last_err);
        end
        idle(10);
        checks++;
        if (bus.Error !== 1'b1 || bus.Dato !== 16'h4021) begin
            failures++;
            $display("FAIL invalid_hold got err=%b dato=%h want 1 4021", bus.Error, bus.Dato);
        end
    endtask

    task automatic test_multi_low();
        clear_obs();
        for (int k = 0; k < 32; k++) cycle(4'b1100, 7'b0110000, 1'b0);
        dwell(2, 7'b0010010, 16);
        dwell(3, 7'b0000010, 16);
        idle(4);
        checks++;
        if (dut_pulses !== 0) begin
            failures++;
            $display("FAIL multi_low_no_capture got=%0d want=0", dut_pulses);
        end
        dwell(0, 7'b1111000, 16);
        dwell(1, 7'b0000000, 16);
        idle(4);
        checks++;
        if (dut_pulses !== 1 || dut_last_dato !== 16'h6587 || dut_last_inv !== 4'h0) begin
            failures++;
            $display("FAIL multi_low_frame got pulses=%0d dato=%h inv=%b want 1 6587 0000",
                     dut_pulses, dut_last_dato, dut_last_inv);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        dwell(0, 7'b1111001, 16);
        dwell(1, 7'b0100100, 16);
        for (int k = 0; k < 3; k++) cycle(4'hF, 7'h7F, 1'b1);
        checks++;
        if (bus.Dato !== 16'h0 || bus.Error !== 1'b0 || bus.Invalidos !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_clear got dato=%h err=%b inv=%b want 0", bus.Dato,
                     bus.Error, bus.Invalidos);
        end
        dwell(0, 7'b0001000, 16);
        dwell(1, 7'b0000011, 16);
        dwell(2, 7'b1000110, 16);
        dwell(3, 7'b0100001, 16);
        idle(4);
        checks++;
        if (dut_pulses !== 1 || dut_last_dato !== 16'hDCBA || dut_last_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_frame got pulses=%0d dato=%h err=%b want 1 dcba 0",
                     dut_pulses, dut_last_dato, dut_last_err);
        end
        checks++;
        if (out_mm !== 0) begin
            failures++;
            $display("FAIL reset_mid_trace mismatched_cycles=%0d want=0", out_mm);
        end
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
        clear_obs();
        for (int d = 0; d < 300; d++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < 2; k++) cycle(4'hF, 7'h7F, 1'b1);
                continue;
            end
            if ($urandom_range(0, 3) != 0) begin
                an = 4'hF;
                an[$urandom_range(0, 3)] = 1'b0;
            end else begin
                an = 4'($urandom);
            end
            seg = ($urandom_range(0, 4) != 0) ? pat_tab[$urandom_range(0, 15)] : 7'($urandom);
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) cycle(an, seg, 1'b0);
        end
        idle(12);
        checks++;
        if (dut_pulses !== mdl_pulses) begin
            failures++;
            $display("FAIL random_pulses got=%0d want=%0d", dut_pulses, mdl_pulses);
        end
        checks++;
        if (dut_last_dato !== mdl_last_dato || dut_last_inv !== mdl_last_inv ||
            dut_last_err !== mdl_last_err) begin
            failures++;
            $display("FAIL random_last got dato=%h inv=%b err=%b want dato=%h inv=%b err=%b",
                     dut_last_dato, dut_last_inv, dut_last_err, mdl_last_dato, mdl_last_inv,
                     mdl_last_err);
        end
        checks++;
        if (out_mm !== 0) begin
            failures++;
            $display("FAIL random_trace mismatched_cycles=%0d want=0", out_mm);
        end
    endtask

    initial begin
        pat_tab[0]  = 7'b1000000;
        pat_tab[1]  = 7'b1111001;
        pat_tab[2]  = 7'b0100100;
        pat_tab[3]  = 7'b0110000;
        pat_tab[4]  = 7'b0011001;
        pat_tab[5]  = 7'b0010010;
        pat_tab[6]  = 7'b0000010;
        pat_tab[7]  = 7'b1111000;
        pat_tab[8]  = 7'b0000000;
        pat_tab[9]  = 7'b0011000;
        pat_tab[10] = 7'b0001000;
        pat_tab[11] = 7'b0000011;
        pat_tab[12] = 7'b1000110;
        pat_tab[13] = 7'b0100001;
        pat_tab[14] = 7'b0000110;
        pat_tab[15] = 7'b0001110;
        Reset = 1'b1;
        bus.Anodos = 4'hF;
        bus.Segmentos = 7'h7F;
        model_edge(4'hF, 7'h7F, 1'b1);

        test_reset();
        test_scan();
        test_debounce();
        test_invalid();
        test_multi_low();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
